// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B over WIDTH cycles with borrow and overflow flags
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic             overflow_out
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic [CW-1:0]    cnt;
  logic             bor, d, bout;
  assign d    = a_sr[0] ^ b_sr[0] ^ bor;
  assign bout = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bor);
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      a_sr         <= '0;
      b_sr         <= '0;
      r_sr         <= '0;
      cnt          <= '0;
      bor          <= 1'b0;
      diff_out     <= '0;
      borrow_out   <= 1'b0;
      overflow_out <= 1'b0;
    end else if (state == S_IDLE) begin
      if (start) begin
        a_sr  <= in_A;
        b_sr  <= in_B;
        bor   <= 1'b0;
        cnt   <= '0;
        state <= S_RUN;
      end
    end else if (state == S_RUN) begin
      a_sr <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr <= {1'b0, b_sr[WIDTH-1:1]};
      r_sr <= {d, r_sr[WIDTH-1:1]};
      bor  <= bout;
      cnt  <= cnt + 1'b1;
      // On the last bit a_sr[0]/b_sr[0] are the original sign bits
      if (cnt == CW'(WIDTH - 1)) begin
        state        <= S_DONE;
        diff_out     <= {d, r_sr[WIDTH-1:1]};
        borrow_out   <= bout;
        overflow_out <= (a_sr[0] ^ b_sr[0]) & (d ^ a_sr[0]);
      end
    end else begin
      state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks against an arithmetic reference model
module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in_A = '0, in_B = '0;
  logic       busy, done, borrow_out, overflow_out;
  logic [7:0] diff_out;
  int vec = 0, err = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_A(in_A), .in_B(in_B),
    .busy(busy), .done(done), .diff_out(diff_out),
    .borrow_out(borrow_out), .overflow_out(overflow_out)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b);
    int sa, sb, sr;
    logic [8:0] t;
    t  = {1'b0, a} - {1'b0, b};
    sa = int'($signed(a));
    sb = int'($signed(b));
    sr = sa - sb;
    return {t[7:0], a < b, (sr > 127 || sr < -128)};
  endfunction

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, output int lat,
                       output logic [9:0] res, output logic busy1, output logic glitch,
                       output logic done_after);
    logic [9:0] prev;
    @(negedge clk);
    in_A = a; in_B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_A = 8'($urandom); in_B = 8'($urandom);
    busy1 = busy;
    prev = {diff_out, borrow_out, overflow_out};
    glitch = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!done && {diff_out, borrow_out, overflow_out} !== prev) glitch = 1'b1;
    end while (!done && lat < 40);
    res = {diff_out, borrow_out, overflow_out};
    @(posedge clk); #1;
    done_after = done | busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vec++;
    if ({busy, done, diff_out, borrow_out, overflow_out} !== 12'h0) begin
      err++; $display("FAIL reset_outputs: got %h want 000", {busy, done, diff_out, borrow_out, overflow_out});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    vec++;
    if (busy !== 1'b0) begin err++; $display("FAIL idle_no_start: busy got %b want 0", busy); end
  endtask

  task automatic test_directed();
    logic [7:0] ta [4] = '{8'd100, 8'h00, 8'h80, 8'h7F};
    logic [7:0] tb [4] = '{8'd37, 8'h01, 8'h01, 8'hFF};
    logic [9:0] want [4] = '{{8'd63, 2'b00}, {8'hFF, 2'b10}, {8'h7F, 2'b01}, {8'h80, 2'b11}};
    logic [9:0] res;
    int lat;
    logic b1, gl, da;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], lat, res, b1, gl, da);
      vec++;
      if (res !== want[i]) begin err++; $display("FAIL directed%0d_result: got %h want %h", i, res, want[i]); end
      vec++;
      if (lat !== 8) begin err++; $display("FAIL directed%0d_latency: got %0d want 8", i, lat); end
      vec++;
      if (b1 !== 1'b1) begin err++; $display("FAIL directed%0d_busy: got %b want 1", i, b1); end
      vec++;
      if (gl !== 1'b0 || da !== 1'b0) begin
        err++; $display("FAIL directed%0d_hold_pulse: glitch %b done/busy_after %b want 0 0", i, gl, da);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic [9:0] res;
    int lat;
    logic b1, gl, da;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      if (i == 0) begin a = 8'h00; b = 8'h00; end
      if (i == 1) begin a = 8'hFF; b = 8'h00; end
      do_op(a, b, lat, res, b1, gl, da);
      vec++;
      if (res !== model(a, b) || lat !== 8 || gl !== 1'b0 || da !== 1'b0) begin
        err++;
        $display("FAIL random_%02h_%02h: got res %h lat %0d glitch %b after %b want res %h lat 8 0 0",
                 a, b, res, lat, gl, da, model(a, b));
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, first_done;
    logic pbusy;
    logic [9:0] res;
    @(negedge clk);
    in_A = 8'h5A; in_B = 8'h5A; start = 1'b1;
    @(posedge clk); #1;
    n = 0; first_done = -1; pbusy = busy; res = '1;
    do begin
      in_A = 8'($urandom); in_B = 8'($urandom);
      @(posedge clk); #1;
      n++;
      if (done && first_done < 0) begin first_done = n; res = {diff_out, borrow_out, overflow_out}; end
      if (!pbusy && busy) break;
      pbusy = busy;
    end while (n < 40);
    start = 1'b0;
    vec++;
    if (res !== 10'h000) begin err++; $display("FAIL b2b_result: got %h want 000", res); end
    vec++;
    if (first_done !== 8) begin err++; $display("FAIL b2b_latency: got %0d want 8", first_done); end
    vec++;
    if (n !== 10) begin err++; $display("FAIL b2b_reaccept: got %0d edges want 10", n); end
    n = 0;
    while ((busy || done) && n < 40) begin @(posedge clk); #1; n++; end
  endtask

  task automatic test_reset_mid_run();
    logic [9:0] res;
    int lat, seen;
    logic b1, gl, da;
    do_op(8'h7F, 8'hFF, lat, res, b1, gl, da);
    @(negedge clk);
    in_A = 8'h33; in_B = 8'h11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    vec++;
    if ({busy, done, diff_out, borrow_out, overflow_out} !== 12'h0) begin
      err++; $display("FAIL midrun_reset_outputs: got %h want 000", {busy, done, diff_out, borrow_out, overflow_out});
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (done || busy) seen++; end
    vec++;
    if (seen !== 0) begin err++; $display("FAIL midrun_no_done: got %0d active cycles want 0", seen); end
    do_op(8'h10, 8'h20, lat, res, b1, gl, da);
    vec++;
    if (res !== {8'hF0, 2'b10} || lat !== 8) begin
      err++; $display("FAIL post_reset_op: got res %h lat %0d want %h lat 8", res, lat, {8'hF0, 2'b10});
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 Port: in_A  input  WIDTH  minuend; sampled on the edge that accepts start.
REQ-006 Port: in_B  input  WIDTH  subtrahend; sampled on the edge that accepts start.
REQ-007 Port: busy  output  1  high in RUN and DONE states.
REQ-008 Port: done  output  1  one-cycle completion pulse.
REQ-009 Port: diff_out  output  WIDTH  result in_A - in_B, modulo 2^WIDTH.
REQ-010 Port: borrow_out  output  1  final borrow; 1 iff in_A < in_B unsigned.
REQ-011 Port: overflow_out  output  1  two's-complement overflow of the subtraction.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 IDLE with start=1 SHALL latch in_A, in_B into internal shift registers, clear the borrow flip-flop and bit counter, and go to RUN.
REQ-014 IDLE with start=0 SHALL remain in IDLE.
REQ-015 Each RUN cycle SHALL process one bit, LSB first, as a full subtractor: d = a XOR b XOR bin; bout = (~a & b) | (~(a XOR b) & bin).
REQ-016 Each d bit SHALL shift into the internal result register from the MSB end; bout SHALL load the borrow flip-flop.
REQ-017 RUN SHALL last exactly WIDTH cycles; the edge processing bit WIDTH-1 SHALL go to DONE.
REQ-018 That same edge SHALL update diff_out, borrow_out and overflow_out.
REQ-019 overflow_out SHALL be 1 iff in_A[MSB] != in_B[MSB] and diff[MSB] != in_A[MSB].
REQ-020 done SHALL be 1 exactly while in DONE; DONE SHALL return to IDLE on the next edge unconditionally.
REQ-021 Latency: done SHALL rise WIDTH edges after the edge that accepted start.
REQ-022 start SHALL be ignored in RUN and DONE; in_A/in_B changes after acceptance SHALL NOT affect the result.
REQ-023 With start held high, accepts SHALL occur every WIDTH+2 edges.
REQ-024 diff_out, borrow_out and overflow_out SHALL hold their values until the next completion; no intermediate values SHALL appear on them.
REQ-025 busy SHALL be 0 exactly when the FSM is in IDLE.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, clear all internal registers, and drive busy, done, diff_out, borrow_out and overflow_out to 0, independent of clk.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-028 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-029 in_A=100, in_B=37, start pulse -> busy high next cycle; done 8 edges after accept; diff_out=63, borrow_out=0, overflow_out=0.
REQ-030 in_A=0x00, in_B=0x01 -> diff_out=0xFF, borrow_out=1, overflow_out=0.
REQ-031 in_A=0x80, in_B=0x01 -> diff_out=0x7F, borrow_out=0, overflow_out=1.
REQ-032 in_A=0x7F, in_B=0xFF -> diff_out=0x80, borrow_out=1, overflow_out=1.
REQ-033 Accept with A=0x5A, B=0x5A, then change in_A/in_B and keep start high during RUN -> diff_out=0x00, borrow_out=0; next accept exactly 10 edges after the first.
REQ-034 Assert rst_n=0 mid-clock during the 4th RUN cycle -> all outputs 0 at once; no done pulse. Then start with A=0x10, B=0x20 -> diff_out=0xF0, borrow_out=1, overflow_out=0.
